// File: rtl/dff_p_d_latch.sv
// d_latch: level-sensitive D latch, transparent while en is high, holding while en is low.
module d_latch #(
  parameter int WIDTH = 1
) (
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_latch
    if (en) q <= d;
endmodule

// File: rtl/dff_p.sv
// dff_p: posedge D flip-flop with synchronous active-high reset, built as a master-slave latch pair.
module dff_p #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);
  logic [WIDTH-1:0] d_int;
  logic [WIDTH-1:0] master_q;
  // reset mux sits ahead of the master so reset only lands on a rising edge
  assign d_int = rst ? RESET_VALUE : in;
  d_latch #(.WIDTH(WIDTH)) u_master (.en(~clk), .d(d_int),    .q(master_q));
  d_latch #(.WIDTH(WIDTH)) u_slave  (.en(clk),  .d(master_q), .q(out));
endmodule

// File: tb/tb_dff_p.sv
// tb_dff_p: directed checks of dff_p for 1-bit and 8-bit (RESET_VALUE 8'h3C) instances.
module tb_dff_p;
  logic       clk;
  logic       rst;
  logic       in;
  logic       out;
  logic       rst8;
  logic [7:0] in8;
  logic [7:0] out8;
  logic       o0;
  int         n_run;
  int         n_fail;
  dff_p u_dut (.clk(clk), .rst(rst), .in(in), .out(out));
  dff_p #(.WIDTH(8), .RESET_VALUE(8'h3C)) u_dut8 (.clk(clk), .rst(rst8), .in(in8), .out(out8));
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic pos();
    #1 clk = 1'b1;
    #1;
  endtask
  task automatic neg();
    #1 clk = 1'b0;
    #1;
  endtask
  initial begin
    n_run  = 0;
    n_fail = 0;
    clk    = 1'b0;
    rst    = 1'b0;
    in     = 1'b0;
    rst8   = 1'b0;
    in8    = 8'h00;
    #1 o0 = out;
    in = 1'b1;
    #1 chk("no_edge_in1", {7'b0, out}, {7'b0, o0});
    in = 1'b0;
    #1 chk("no_edge_in0", {7'b0, out}, {7'b0, o0});
    in = 1'b1;
    #1 chk("no_edge_in1b", {7'b0, out}, {7'b0, o0});
    pos();
    chk("capture_1", {7'b0, out}, 8'h01);
    in = 1'b0;
    #1 chk("hold_clk_high", {7'b0, out}, 8'h01);
    in = 1'b1;
    neg();
    chk("hold_after_fall", {7'b0, out}, 8'h01);
    in = 1'b0;
    #1 chk("hold_clk_low", {7'b0, out}, 8'h01);
    in = 1'b1;
    #1 in = 1'b0;
    pos();
    chk("capture_0", {7'b0, out}, 8'h00);
    neg();
    rst = 1'b1;
    in  = 1'b1;
    pos();
    chk("rst_priority", {7'b0, out}, 8'h00);
    neg();
    rst = 1'b0;
    pos();
    chk("rst_release", {7'b0, out}, 8'h01);
    neg();
    rst = 1'b1;
    #1 chk("rst_waits_edge", {7'b0, out}, 8'h01);
    pos();
    chk("rst_on_edge", {7'b0, out}, 8'h00);
    rst = 1'b0;
    #1 chk("release_clk_high", {7'b0, out}, 8'h00);
    neg();
    chk("release_clk_low", {7'b0, out}, 8'h00);
    pos();
    chk("resume_capture", {7'b0, out}, 8'h01);
    in8 = 8'hA5;
    neg();
    pos();
    chk("w8_capture_a5", out8, 8'hA5);
    rst8 = 1'b1;
    neg();
    chk("w8_rst_pending", out8, 8'hA5);
    pos();
    chk("w8_reset_3c", out8, 8'h3C);
    rst8 = 1'b0;
    in8  = 8'h5A;
    neg();
    pos();
    chk("w8_capture_5a", out8, 8'h5A);
    chk("w1_unaffected", {7'b0, out}, 8'h01);
    neg();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
